// File: rtl/multicycle_ctrl_pkg.sv
// Shared controller definitions: state encodings, opcode/funct constants,
// ALU operation codes, fault causes and the wait-counter width helper.
// Imported by the decoder and the FSM so both agree on every encoding.
package multicycle_ctrl_pkg;

  // One-hot controller states
  typedef enum logic [5:0] {
    S_IF  = 6'b000001,
    S_ID  = 6'b000010,
    S_EX  = 6'b000100,
    S_MEM = 6'b001000,
    S_WB  = 6'b010000,
    S_ERR = 6'b100000
  } state_t;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  // funct7 values: base form and the SUB/SRA alternate form
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // Fault causes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Wait counter must hold 0..max_wait; never narrower than one bit
  function automatic int wait_width(input int max_wait);
    if (max_wait < 1) return 1;
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps instr to ALUCtrl/ALUSrc and flags unsupported encodings.
// Purely combinational, zero latency; no handshake.
// Illegal encodings force ALUCtrl to the AND code and ALUSrc low.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  ALUCtrl,
  output logic        ALUSrc,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] code;
  logic       ok;
  logic       src;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  // Register and immediate fields play no part in decoding
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  // Decode opcode/funct3/funct7 into an ALU code and a legality flag
  always_comb begin
    code = ALU_AND;
    ok   = 1'b0;
    src  = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_BASE) begin code = ALU_ADD; ok = 1'b1; end
            else if (funct7 == F7_ALT) begin code = ALU_SUB; ok = 1'b1; end
          end
          F3_SR: begin
            if (funct7 == F7_BASE) begin code = ALU_SRL; ok = 1'b1; end
            else if (funct7 == F7_ALT) begin code = ALU_SRA; ok = 1'b1; end
          end
          F3_SLL: begin code = ALU_SLL; ok = (funct7 == F7_BASE); end
          F3_SLT: begin code = ALU_SLT; ok = (funct7 == F7_BASE); end
          F3_XOR: begin code = ALU_XOR; ok = (funct7 == F7_BASE); end
          F3_OR:  begin code = ALU_OR;  ok = (funct7 == F7_BASE); end
          F3_AND: begin code = ALU_AND; ok = (funct7 == F7_BASE); end
          default: ok = 1'b0;
        endcase
      end
      OP_I: begin
        src = 1'b1;
        case (funct3)
          F3_ADD: begin code = ALU_ADD; ok = 1'b1; end
          F3_SLT: begin code = ALU_SLT; ok = 1'b1; end
          F3_XOR: begin code = ALU_XOR; ok = 1'b1; end
          F3_OR:  begin code = ALU_OR;  ok = 1'b1; end
          F3_AND: begin code = ALU_AND; ok = 1'b1; end
          // Shift immediates carry funct7 in the upper immediate bits
          F3_SLL: begin code = ALU_SLL; ok = (funct7 == F7_BASE); end
          F3_SR: begin
            if (funct7 == F7_BASE) begin code = ALU_SRL; ok = 1'b1; end
            else if (funct7 == F7_ALT) begin code = ALU_SRA; ok = 1'b1; end
          end
          default: ok = 1'b0;
        endcase
      end
      OP_LOAD: begin
        code = ALU_ADD; src = 1'b1; ok = (funct3 == F3_LW);
      end
      OP_STORE: begin
        code = ALU_ADD; src = 1'b1; ok = (funct3 == F3_SW);
      end
      OP_BRANCH: begin
        code = ALU_SUB; src = 1'b0; ok = (funct3 == F3_BEQ);
      end
      default: ok = 1'b0;
    endcase
  end

  assign illegal = ~ok;
  assign ALUCtrl = ok ? code : ALU_AND;
  assign ALUSrc  = ok & src;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: IF/ID/EX/[MEM]/WB sequencing with fault trapping.
// One state per cycle; MEM stretches until dReady or the wait limit.
// dReady is the only stall source; ERR is terminal until rst.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int SKIP_MEM     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        dReady,
  output logic        loadPC,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic [5:0]  state,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] retired
);

  localparam int WW   = wait_width(MEM_WAIT_MAX);
  localparam int LAST = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
  localparam logic [WW-1:0] WAIT_LAST = WW'(LAST);

  state_t        cur, nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [1:0]    code_q, code_nxt;
  logic          illegal;
  logic          is_load, is_store, is_mem, is_beq, writes_reg;

  alu_decoder u_dec (
    .instr   (instr),
    .ALUCtrl (ALUCtrl),
    .ALUSrc  (ALUSrc),
    .illegal (illegal)
  );

  // Instruction class; legality has already been screened in ID
  assign is_load    = (instr[6:0] == OP_LOAD);
  assign is_store   = (instr[6:0] == OP_STORE);
  assign is_mem     = is_load | is_store;
  assign is_beq     = (instr[6:0] == OP_BRANCH);
  assign writes_reg = (instr[6:0] == OP_R) | (instr[6:0] == OP_I) | is_load;

  // State, wait counter, fault cause and retire count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_IF;
      wait_cnt <= '0;
      code_q   <= ERR_NONE;
      retired  <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      code_q   <= code_nxt;
      if (cur == S_WB) retired <= retired + 32'd1;
    end
  end

  // Next-state logic, including MEM wait timeout
  always_comb begin
    nxt      = cur;
    wait_nxt = wait_cnt;
    code_nxt = code_q;
    case (cur)
      S_IF: nxt = S_ID;
      S_ID: begin
        if (illegal) begin
          nxt      = S_ERR;
          code_nxt = ERR_ILLEGAL;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        if (is_mem || SKIP_MEM == 0) begin
          nxt      = S_MEM;
          wait_nxt = '0;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        // Completion on the last permitted cycle takes priority over timeout
        if (!is_mem || dReady) begin
          nxt = S_WB;
        end else if (MEM_WAIT_MAX != 0 && wait_cnt == WAIT_LAST) begin
          nxt      = S_ERR;
          code_nxt = ERR_TIMEOUT;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      S_WB:    nxt = S_IF;
      S_ERR:   nxt = S_ERR;
      default: nxt = S_IF;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    case (cur)
      S_MEM: begin
        MemRead  = is_load;
        MemWrite = is_store;
      end
      S_WB: begin
        loadPC   = 1'b1;
        PCSrc    = is_beq & zero;
        RegWrite = writes_reg;
        MemToReg = is_load;
      end
      default: ;
    endcase
  end

  assign state    = cur;
  assign err      = (cur == S_ERR);
  assign err_code = code_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one instance with a short wait limit
// and memory skipping, one that always visits MEM and never times out.
module tb_multicycle_ctrl;

  logic        clk, rst, zero, dReady;
  logic [31:0] instr;

  logic        loadPC, PCSrc, RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, err;
  logic [3:0]  ALUCtrl;
  logic [5:0]  state;
  logic [1:0]  err_code;
  logic [31:0] retired;

  logic        loadPC2, PCSrc2, RegWrite2, MemToReg2, MemRead2, MemWrite2, ALUSrc2, err2;
  logic [3:0]  ALUCtrl2;
  logic [5:0]  state2;
  logic [1:0]  err_code2;
  logic [31:0] retired2;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.MEM_WAIT_MAX(4), .SKIP_MEM(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dReady(dReady),
    .loadPC(loadPC), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
    .state(state), .err(err), .err_code(err_code), .retired(retired)
  );

  multicycle_ctrl #(.MEM_WAIT_MAX(0), .SKIP_MEM(0)) dut2 (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dReady(dReady),
    .loadPC(loadPC2), .PCSrc(PCSrc2), .RegWrite(RegWrite2), .MemToReg(MemToReg2),
    .MemRead(MemRead2), .MemWrite(MemWrite2), .ALUSrc(ALUSrc2), .ALUCtrl(ALUCtrl2),
    .state(state2), .err(err2), .err_code(err_code2), .retired(retired2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam int ND = 13;
  logic [31:0] dec_in  [ND] = '{32'h40000033, 32'h40005033, 32'h00002033, 32'h00004013,
                                32'h40005013, 32'h00001013, 32'h40001013, 32'h00003033,
                                32'h02000033, 32'h00007033, 32'h00006013, 32'h00005033,
                                32'h00001063};
  logic [3:0]  dec_alu [ND] = '{4'b0110, 4'b1010, 4'b0111, 4'b1101,
                                4'b1010, 4'b1001, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0001, 4'b1000,
                                4'b0000};
  logic        dec_src [ND] = '{1'b0, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0,
                                1'b0};

  initial begin
    rst = 1'b1; instr = 32'h0; zero = 1'b0; dReady = 1'b0;

    // Reset state
    #3;
    check("rst_state", 32'(state), 32'h01);
    check("rst_retired", retired, 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_memread", 32'(MemRead), 0);

    // ADDI x1,x0,5
    instr = 32'h00500093;
    do_reset();
    check("addi_if", 32'(state), 32'h01);
    check("addi_alu", 32'(ALUCtrl), 4'b0010);
    check("addi_src", 32'(ALUSrc), 1);
    check("addi_if_rw", 32'(RegWrite), 0);
    step();
    check("addi_id", 32'(state), 32'h02);
    check("addi_id_pc", 32'(loadPC), 0);
    step();
    check("addi_ex", 32'(state), 32'h04);
    check("addi_ex_rw", 32'(RegWrite), 0);
    step();
    check("addi_wb", 32'(state), 32'h10);
    check("addi_wb_rw", 32'(RegWrite), 1);
    check("addi_wb_pc", 32'(loadPC), 1);
    check("addi_wb_m2r", 32'(MemToReg), 0);
    check("noskip_mem", 32'(state2), 32'h08);
    check("noskip_mem_strobe", 32'({MemRead2, MemWrite2}), 0);
    step();
    check("addi_if2", 32'(state), 32'h01);
    check("addi_pc_pulse", 32'(loadPC), 0);
    check("addi_retired", retired, 1);
    check("noskip_wb", 32'(state2), 32'h10);
    check("noskip_wb_rw", 32'(RegWrite2), 1);
    step();
    check("noskip_retired", retired2, 1);

    // LW x2,0(x0), dReady on third MEM cycle
    instr = 32'h00002103; dReady = 1'b0;
    do_reset();
    step(); step();
    check("lw_ex_rd", 32'(MemRead), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lw_mem_state", 32'(state), 32'h08);
      check("lw_mem_rd", 32'(MemRead), 1);
    end
    dReady = 1'b1;
    step();
    dReady = 1'b0;
    check("lw_wb", 32'(state), 32'h10);
    check("lw_wb_m2r", 32'(MemToReg), 1);
    check("lw_wb_rw", 32'(RegWrite), 1);
    check("lw_wb_rd", 32'(MemRead), 0);
    check("lw_noskip_wb", 32'(state2), 32'h10);
    step();
    check("lw_if", 32'(state), 32'h01);
    check("lw_retired", retired, 1);

    // Second LW interrupted by reset in its second MEM cycle
    step(); step(); step(); step();
    check("lwr_mem2", 32'(state), 32'h08);
    check("lwr_mem2_rd", 32'(MemRead), 1);
    rst = 1'b1;
    #1;
    check("lwr_rd_drop", 32'(MemRead), 0);
    check("lwr_state", 32'(state), 32'h01);
    check("lwr_retired", retired, 0);
    check("lwr_state2", 32'(state2), 32'h01);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // BEQ x0,x0,0
    instr = 32'h00000063; zero = 1'b1;
    do_reset();
    check("beq_alu", 32'(ALUCtrl), 4'b0110);
    check("beq_src", 32'(ALUSrc), 0);
    step(); step();
    check("beq_ex_pcsrc", 32'(PCSrc), 0);
    step();
    check("beq_wb", 32'(state), 32'h10);
    check("beq_pcsrc1", 32'(PCSrc), 1);
    check("beq_rw", 32'(RegWrite), 0);
    zero = 1'b0;
    #1;
    check("beq_pcsrc0", 32'(PCSrc), 0);

    // SW with dReady held low: timeout after four MEM cycles
    instr = 32'h00102023; dReady = 1'b0;
    do_reset();
    check("sw_src", 32'(ALUSrc), 1);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("swt_mem_wr", 32'(MemWrite), 1);
      check("swt_mem_state", 32'(state), 32'h08);
    end
    step();
    check("swt_err_state", 32'(state), 32'h20);
    check("swt_err", 32'(err), 1);
    check("swt_err_code", 32'(err_code), 2'b10);
    check("swt_wr_off", 32'(MemWrite), 0);
    check("nolimit_mem", 32'(state2), 32'h08);
    check("nolimit_err", 32'(err2), 0);
    dReady = 1'b1;
    step(); step();
    dReady = 1'b0;
    check("swt_sticky", 32'(state), 32'h20);
    check("swt_sticky_code", 32'(err_code), 2'b10);
    check("swt_strobes", 32'({loadPC, PCSrc, RegWrite, MemToReg, MemRead, MemWrite}), 0);
    check("swt_retired", retired, 0);

    // SW with dReady on the fourth (final permitted) MEM cycle
    do_reset();
    step(); step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("sws_mem_wr", 32'(MemWrite), 1);
    end
    dReady = 1'b1;
    step();
    dReady = 1'b0;
    check("sws_wb", 32'(state), 32'h10);
    check("sws_err", 32'(err), 0);
    check("sws_rw", 32'(RegWrite), 0);
    step();
    check("sws_retired", retired, 1);

    // Illegal instruction
    instr = 32'hFFFFFFFF;
    do_reset();
    check("ill_alu", 32'(ALUCtrl), 0);
    step();
    check("ill_id", 32'(state), 32'h02);
    step();
    check("ill_err_state", 32'(state), 32'h20);
    check("ill_err_code", 32'(err_code), 2'b01);
    check("ill_err", 32'(err), 1);
    check("ill_err_code2", 32'(err_code2), 2'b01);
    for (int i = 0; i < 3; i++) begin
      check("ill_pc", 32'(loadPC), 0);
      step();
    end
    check("ill_retired", retired, 0);

    // Decoder table, exercised while parked in ERR
    for (int i = 0; i < ND; i++) begin
      instr = dec_in[i];
      #1;
      check($sformatf("dec_alu_%0d", i), 32'(ALUCtrl), 32'(dec_alu[i]));
      check($sformatf("dec_src_%0d", i), 32'(ALUSrc), 32'(dec_src[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum consecutive MEM cycles with dReady=0 before a timeout; 0 disables the timeout.
REQ-002 Parameter SKIP_MEM, default 1: 1 means non-memory instructions bypass MEM; 0 means every instruction visits MEM for one cycle.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 instr  in  32  current instruction, stable from IF through WB.
REQ-006 zero  in  1  ALU zero flag from the datapath.
REQ-007 dReady  in  1  data-memory completion handshake.
REQ-008 loadPC, PCSrc, RegWrite, MemToReg, MemRead, MemWrite, ALUSrc  out  1 each  datapath control strobes.
REQ-009 ALUCtrl  out  4  ALU operation code.
REQ-010 state  out  6  one-hot current state.
REQ-011 err  out  1  sticky fault flag.
REQ-012 err_code  out  2  fault cause: 01 = illegal instruction, 10 = memory timeout.
REQ-013 retired  out  32  count of completed instructions.

Function
REQ-014 The FSM SHALL have states IF=000001, ID=000010, EX=000100, MEM=001000, WB=010000 and ERR=100000.
REQ-015 IF SHALL go to ID.
- ID SHALL go to ERR with err_code=01 when the instruction is illegal, otherwise to EX.
REQ-016 EX SHALL go to MEM for load/store or when SKIP_MEM=0, and otherwise to WB.
REQ-017 MEM with load/store SHALL hold MemRead (load) or MemWrite (store) high every MEM cycle and go to WB on the cycle dReady=1.
- MEM with a non-memory instruction SHALL last one cycle with no strobes.
REQ-018 The wait counter SHALL clear on MEM entry and increment each MEM cycle with dReady=0.
- Reaching MEM_WAIT_MAX (when nonzero) SHALL enter ERR with err_code=10.
- dReady=1 on the final permitted cycle SHALL win, going to WB.
REQ-019 WB SHALL hold loadPC=1 for exactly one cycle, then go to IF.
- RegWrite=1 for R-type, I-type ALU and LW.
- MemToReg=1 for LW only.
- PCSrc = (BEQ and zero).
REQ-020 ERR SHALL drive all strobes 0, keep err=1 and err_code, and leave ERR only on rst.
REQ-021 Strobes SHALL be 0 in IF, ID and EX.
- ALUCtrl and ALUSrc are combinational from instr in every state.
REQ-022 ALUCtrl SHALL be: AND/ANDI 0000, OR/ORI 0001, ADD/ADDI/LW/SW 0010, SUB/BEQ 0110, SLT/SLTI 0111, SRL/SRLI 1000, SLL/SLLI 1001, SRA/SRAI 1010, XOR/XORI 1101.
REQ-023 ALUSrc SHALL be 1 for I-type ALU, LW and SW, and 0 for R-type and BEQ.
REQ-024 An instruction SHALL be illegal when:
- its opcode is not 0110011, 0010011, 0000011, 0100011 or 1100011; or
- its funct3/funct7 pair is unlisted in REQ-022 (this includes funct7 other than 0000000/0100000 on shifts and ADD/SUB).
- An illegal instruction SHALL produce ALUCtrl=0000.
REQ-025 retired SHALL increment by 1 on each WB cycle, wrap from FFFFFFFF to 0, and never increment in ERR.

Reset
REQ-026 While rst=1, the block SHALL asynchronously force state=IF, all strobes 0, err=0, err_code=00, retired=0 and wait counter 0.
REQ-027 rst asserted mid-MEM SHALL drop MemRead/MemWrite in the same cycle with no WB.

Structure
REQ-028 A shared include file ctrl_defs.vh SHALL hold the state encodings, opcode constants, funct3 constants, ALUCtrl codes and err_code values.
REQ-029 A combinational sub-module alu_decoder SHALL produce ALUCtrl, ALUSrc and illegal from instr.
- The FSM, wait counter and retired counter SHALL reside in multicycle_ctrl.
REQ-030 The wait counter width SHALL be clog2(MEM_WAIT_MAX+1), minimum 1.

Verification
REQ-031 ADDI x1,x0,5 (00500093), SKIP_MEM=1 -> IF,ID,EX,WB in 4 cycles; ALUCtrl=0010, ALUSrc=1; RegWrite=1 only in WB; loadPC one pulse; retired=1.
REQ-032 LW x2,0(x0) (00002103), dReady=1 on 3rd MEM cycle -> MemRead high 3 cycles; WB with MemToReg=1, RegWrite=1; 7 cycles total.
REQ-033 BEQ x0,x0,0 (00000063): zero=1 -> PCSrc=1, RegWrite=0 in WB; zero=0 -> PCSrc=0; ALUCtrl=0110.
REQ-034 SW (00102023), MEM_WAIT_MAX=4, dReady held 0 -> MemWrite high 4 cycles, then ERR with err_code=10 and strobes 0 until rst.
- Repeat with dReady=1 on the 4th cycle -> WB, no error.
REQ-035 instr FFFFFFFF -> ID then ERR, err_code=01, loadPC never asserted, retired unchanged.
REQ-036 rst pulsed in 2nd MEM cycle of LW -> MemRead=0 immediately, state=000001, retired=0.
